// File: rtl/cl_div_pkg.sv
// rtl/cl_div_pkg.sv - shared types and GF(2) long-division step helpers for cl_div_seq
package cl_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the step helpers are written for; callers size down with casts.
    localparam int MAX_W = 64;
    typedef logic [MAX_W:0] poly_t;

    function automatic int cnt_w(input int w);
        return $clog2(2 * w + 1);
    endfunction

    function automatic int deg_w(input int w);
        return $clog2(w + 1);
    endfunction

    // Quotient bit produced by shifting the next dividend bit into the partial remainder.
    function automatic logic cl_div_qbit(input poly_t r, input logic b, input int deg);
        poly_t t;
        t = (r << 1) | poly_t'(b);
        return t[deg];
    endfunction

    // Partial remainder after one step; bits at or above deg are always zero on return.
    function automatic poly_t cl_div_step(input poly_t r, input logic b, input poly_t divisor,
                                          input int deg);
        poly_t t;
        t = (r << 1) | poly_t'(b);
        return t[deg] ? (t ^ divisor) : t;
    endfunction

endpackage

// File: rtl/cl_div_deg_enc.sv
// rtl/cl_div_deg_enc.sv - priority encoder: divisor polynomial -> degree and zero flag
module cl_div_deg_enc
    import cl_div_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W:0]            i_divisor,
    output logic [deg_w(W)-1:0]   o_deg,
    output logic                  o_zero
);
    localparam int DEG_W = deg_w(W);

    always_comb begin
        o_deg = '0;
        for (int i = 0; i <= W; i++) begin
            if (i_divisor[i]) o_deg = DEG_W'(i);
        end
    end

    assign o_zero = ~|i_divisor;

endmodule

// File: rtl/cl_div_seq.sv
// rtl/cl_div_seq.sv - sequential carry-less polynomial divider (start/busy/done)
// CL_DIV_RADIX4_EN selects two quotient bits per cycle; default build is one bit per cycle.
module cl_div_seq
    import cl_div_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [2*DATA_WIDTH-1:0]   dividend,
    input  logic [DATA_WIDTH:0]       divisor,
    output logic                      busy,
    output logic                      done,
    output logic                      div_zero,
    output logic [2*DATA_WIDTH-1:0]   quotient,
    output logic [DATA_WIDTH-1:0]     remainder
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = cnt_w(W);
    localparam int DEG_W = deg_w(W);
`ifdef CL_DIV_RADIX4_EN
    localparam int SPC = 2;
`else
    localparam int SPC = 1;
`endif
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * W / SPC - 1);

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*W-1:0]     r_dvd;
    logic [W:0]         r_dvs;
    logic [DEG_W-1:0]   r_deg;
    logic [2*W-1:0]     r_quo;
    logic [W-1:0]       r_rem;
    logic               r_busy;
    logic               r_done;
    logic               r_dz;

    logic [DEG_W-1:0]   w_deg;
    logic               w_zero;
    logic               w_q0;
    logic [W-1:0]       w_r0;
    logic [2*W-1:0]     w_dvd_nxt;
    logic [2*W-1:0]     w_quo_nxt;
    logic [W-1:0]       w_rem_nxt;

    cl_div_deg_enc #(.W(W)) u_deg_enc (
        .i_divisor (divisor),
        .o_deg     (w_deg),
        .o_zero    (w_zero)
    );

    assign w_q0 = cl_div_qbit(poly_t'(r_rem), r_dvd[2*W-1], int'(r_deg));
    assign w_r0 = W'(cl_div_step(poly_t'(r_rem), r_dvd[2*W-1], poly_t'(r_dvs), int'(r_deg)));

`ifdef CL_DIV_RADIX4_EN
    logic           w_q1;
    logic [W-1:0]   w_r1;

    // Second stage consumes the first stage's remainder within the same cycle.
    assign w_q1      = cl_div_qbit(poly_t'(w_r0), r_dvd[2*W-2], int'(r_deg));
    assign w_r1      = W'(cl_div_step(poly_t'(w_r0), r_dvd[2*W-2], poly_t'(r_dvs), int'(r_deg)));
    assign w_dvd_nxt = {r_dvd[2*W-3:0], 2'b00};
    assign w_quo_nxt = {r_quo[2*W-3:0], w_q0, w_q1};
    assign w_rem_nxt = w_r1;
`else
    assign w_dvd_nxt = {r_dvd[2*W-2:0], 1'b0};
    assign w_quo_nxt = {r_quo[2*W-2:0], w_q0};
    assign w_rem_nxt = w_r0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_deg   <= '0;
            r_quo   <= '0;
            r_rem   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        r_dvd  <= dividend;
                        r_dvs  <= divisor;
                        r_deg  <= w_deg;
                        r_cnt  <= '0;
                        r_quo  <= '0;
                        r_dz   <= w_zero;
                        if (w_zero) begin
                            r_rem   <= dividend[W-1:0];
                            r_done  <= 1'b1;
                            r_state <= DONE;
                        end else begin
                            r_rem   <= '0;
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_dvd <= w_dvd_nxt;
                    r_quo <= w_quo_nxt;
                    r_rem <= w_rem_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign div_zero  = r_dz;
    assign quotient  = r_quo;
    assign remainder = r_rem;

endmodule

// File: tb/tb_cl_div_seq.sv
// tb/tb_cl_div_seq.sv - randomized scoreboard bench for cl_div_seq against a polynomial long-division model
module tb_cl_div_seq;
    localparam int W = 8;
`ifdef CL_DIV_RADIX4_EN
    localparam int CALC_CYC = W;
`else
    localparam int CALC_CYC = 2 * W;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [2*W-1:0]   dividend = '0;
    logic [W:0]       divisor = '0;
    logic             busy, done, div_zero;
    logic [2*W-1:0]   quotient;
    logic [W-1:0]     remainder;

    cl_div_seq #(.DATA_WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .quotient  (quotient),
        .remainder (remainder)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [2*W-1:0] dvd;
        logic [W:0]     dvs;
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dz;
        int             done_cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pdeg(input logic [63:0] v);
        int d = -1;
        for (int i = 0; i < 64; i++) if (v[i]) d = i;
        return d;
    endfunction

    // Textbook long division: cancel the leading term with a shifted divisor until below deg(divisor).
    task automatic ref_div(input logic [2*W-1:0] a, input logic [W:0] b,
                           output logic [2*W-1:0] q, output logic [W-1:0] r, output logic dz);
        logic [63:0] rem, bx, qq;
        int db;
        rem = 64'(a);
        bx  = 64'(b);
        qq  = '0;
        if (b == '0) begin
            q = '0; r = a[W-1:0]; dz = 1'b1;
        end else begin
            db = pdeg(bx);
            for (int i = 2 * W - 1; i >= db; i--) begin
                if (rem[i]) begin
                    rem ^= bx << (i - db);
                    qq[i - db] = 1'b1;
                end
            end
            q = qq[2*W-1:0]; r = rem[W-1:0]; dz = 1'b0;
        end
    endtask

    function automatic logic [63:0] clmul(input logic [63:0] a, input logic [63:0] b);
        logic [63:0] p = '0;
        for (int i = 0; i < 32; i++) if (a[i]) p ^= b << i;
        return p;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.done_cyc));
                chk("busy_at_done", 64'(busy), 64'd1);
                chk("quotient", 64'(quotient), 64'(e.q));
                chk("remainder", 64'(remainder), 64'(e.r));
                chk("div_zero", 64'(div_zero), 64'(e.dz));
                if (e.dvs != '0) begin
                    chk("clmul_identity", clmul(64'(quotient), 64'(e.dvs)) ^ 64'(remainder), 64'(e.dvd));
                    chk("rem_degree", 64'(remainder) >> pdeg(64'(e.dvs)), 64'd0);
                end
            end
        end
    end

    // Called #2 after a rising edge while the DUT is idle; returns in the first idle cycle after done.
    task automatic issue(input logic [2*W-1:0] a, input logic [W:0] b, input bit given,
                         input logic [2*W-1:0] gq, input logic [W-1:0] gr, input bit glitch);
        exp_t e;
        logic [2*W-1:0] q;
        logic [W-1:0]   r;
        logic           dz;
        int             n;
        ref_div(a, b, q, r, dz);
        if (given) begin q = gq; r = gr; end
        e.dvd = a; e.dvs = b; e.q = q; e.r = r; e.dz = dz;
        e.done_cyc = cyc + ((b == '0) ? 1 : CALC_CYC + 1);
        sb.push_back(e);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        dividend = (2*W)'($urandom);
        divisor  = (W+1)'($urandom);
        if (glitch && b != '0) begin
            repeat (3) @(posedge clk);
            #2;
            chk("busy_in_calc", 64'(busy), 64'd1);
            start = 1'b1;
            dividend = ~a;
            divisor  = (W+1)'(1);
            @(posedge clk); #2;
            start = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        if (sb.size() != 0) begin
            chk("done_timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic reset_mid_calc();
        int a_cyc;
        dividend = 16'hBEEF; divisor = 9'h11B; start = 1'b1;
        a_cyc = cyc;
        @(posedge clk); #2;
        start = 1'b0;
        while (cyc < a_cyc + 5) begin @(posedge clk); #2; end
        rst_n = 1'b0;
        @(posedge clk); #2;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_quotient", 64'(quotient), 64'd0);
        chk("abort_remainder", 64'(remainder), 64'd0);
        chk("abort_div_zero", 64'(div_zero), 64'd0);
        rst_n = 1'b1;
        repeat (2 * CALC_CYC) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [2*W-1:0] a;
        logic [W:0]     b;
        int             d;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk("reset_div_zero", 64'(div_zero), 64'd0);
        chk("reset_quotient", 64'(quotient), 64'd0);
        chk("reset_remainder", 64'(remainder), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        issue(16'h0100, 9'h11B, 1'b1, 16'h0001, 8'h1B, 1'b0);
        issue(16'hABCD, 9'h001, 1'b1, 16'hABCD, 8'h00, 1'b0);
        issue(16'hABCD, 9'h002, 1'b1, 16'h55E6, 8'h01, 1'b0);
        issue(16'h1234, 9'h000, 1'b1, 16'h0000, 8'h34, 1'b0);
        issue(16'hFFFF, 9'h1FF, 1'b0, '0, '0, 1'b1);

        reset_mid_calc();
        issue(16'hBEEF, 9'h11B, 1'b0, '0, '0, 1'b0);

        for (int k = 0; k < 1000; k++) begin
            d = $urandom_range(0, W);
            b = (W+1)'((1 << d) | ($urandom & ((1 << d) - 1)));
            if ($urandom_range(0, 19) == 0) b = '0;
            a = (2*W)'($urandom);
            issue(a, b, 1'b0, '0, '0, (k % 97) == 0);
        end

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
